srio_nread_responder: RTL and testbench
=======================================

Name: srio_nread_responder

Overview:
- Target-side responder for SRIO NREAD requests arriving on the HELLO-format request AXI4-Stream (treq) of the SRIO Gen2 core.
- Serves read data from a local 64-bit word memory and returns RESPONSE-with-data packets on the response stream (tresp).
- Sits beside the user logic behind each srio_example_top instance, so a back-to-back primary/mirror pair can exchange read traffic after link initialization.
- The local memory is filled through a simple write port owned by the user logic.

Parameters:
- MEM_AW, 6, local memory word-address width; depth = 2**MEM_AW words of 64 bits.
- MAX_BEATS, 32, maximum data beats per response (256 bytes).

Ports:
- log_clk  input  1  logic-layer clock; all logic on rising edge
- log_rst_n  input  1  asynchronous active-low reset
- treq_tvalid  input  1  request beat valid
- treq_tready  output  1  request beat accepted
- treq_tdata  input  64  HELLO beat: [63:56] TID, [55:52] FTYPE, [51:48] TTYPE, [46:45] prio, [44] CRF, [43:36] size (bytes-1), [33:0] address
- treq_tkeep  input  8  byte enables (ignored on header beats)
- treq_tlast  input  1  last beat of request
- treq_tuser  input  32  {src_id[15:0], dest_id[15:0]}
- tresp_tvalid  output  1  response beat valid
- tresp_tready  input  1  downstream ready
- tresp_tdata  output  64  response header or data beat
- tresp_tkeep  output  8  always 8'hFF while valid
- tresp_tlast  output  1  last response beat
- tresp_tuser  output  32  {dest_id, src_id} of the request (IDs swapped)
- mem_we  input  1  local memory write strobe
- mem_waddr  input  MEM_AW  local memory word address
- mem_wdata  input  64  local memory write data
- nread_cnt  output  16  NREADs answered; saturates at 16'hFFFF
- drop_cnt  output  16  unsupported requests; saturates at 16'hFFFF
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Memory contents are not reset. Assertion mid-packet aborts immediately: tresp_tvalid drops asynchronously.
- States: IDLE, RESP_HDR, RESP_DATA, DRAIN, ERR_HDR (ERR_HDR exists only with the optional feature).
- IDLE: treq_tready=1. A header beat is supported when all of the following hold:
  - FTYPE=4'h2 and TTYPE=4'h4;
  - address[2:0]=0 and size[2:0]=3'b111;
  - (size+1)/8 <= MAX_BEATS;
  - address[33:MEM_AW+3]=0;
  - treq_tlast=1.
- IDLE transitions: supported → latch TID, prio, CRF, IDs, word pointer = address[MEM_AW+2:3], beats = (size+1)>>3, then go to RESP_HDR. Unsupported → increment drop_cnt, then go to DRAIN if tlast=0, else IDLE.
- DRAIN: treq_tready=1; discard beats until a tlast beat is accepted, then go to IDLE.
- RESP_HDR: tresp_tdata = {TID, 4'hD, 4'h8, 1'b0, prio_r, CRF, 44'h0}, where prio_r = min(prio+1, 3). tlast=0. Go to RESP_DATA on handshake.
- RESP_DATA: emits beats words mem[ptr]..mem[ptr+beats-1]. The pointer wraps modulo 2**MEM_AW. tlast is set on the final beat.
  - With tresp_tready held high, data beats occupy consecutive cycles directly after the header handshake (no bubbles).
  - tdata, tlast and tvalid stay stable while tvalid=1 and tready=0 (AXI rule).
  - The final handshake increments nread_cnt; go to IDLE.
- treq_tready=0 in RESP_HDR, RESP_DATA and ERR_HDR; back-to-back requests are serialized.
- Memory: write and read on the same word in the same cycle return the old data (read-first). Writes are accepted in every state, including reset-release.
- Counters saturate and never wrap.

Optional Feature:
- Macro: SRIO_RESP_ERR_EN.
- Defined: unsupported requests that have FTYPE 2 or 5 go to ERR_HDR after being consumed (and drained). ERR_HDR emits one beat {TID, 4'hD, 4'h0, 1'b0, prio_r, CRF, 8'h0, 4'b0111, 32'h0} with tlast=1 and swapped IDs, then returns to IDLE. drop_cnt still increments.
- Undefined: ERR_HDR does not exist; unsupported requests are silently dropped and counted.

Test Plan:
1. Write words 0–3 = 64'h1111…1..64'h4444…4. Send NREAD TID=8'h5A, addr 0, size 8'h1F, prio 1, tuser 32'h0001_0002. Expect header 64'h5AD8_4000_0000_0000, then 4 data beats in order, tlast on beat 4, tuser 32'h0002_0001, nread_cnt=1.
2. Same request with tresp_tready toggling 1,0,0,1 randomly. Expect identical beat sequence, data stable during stalls, no beat lost or duplicated.
3. NWRITE (FTYPE 5) header plus 3 data beats. Expect all 4 beats accepted, no tresp output (macro off), drop_cnt=1. With SRIO_RESP_ERR_EN: one error beat carrying status 4'b0111.
4. NREAD addr 0x3F8, size 8'h0F, MEM_AW=7. Expect words 127 then 0 (wrap-around).
5. NREAD addr 0x4, size 8'h07. Expect unaligned rejection and drop_cnt increments. Then a valid NREAD is answered normally.
6. Assert log_rst_n low during beat 2 of a 32-beat response. Expect tresp_tvalid=0 immediately, counters 0, and the next request after release answered correctly.

Source files
------------

// File: rtl/srio_nread_responder.sv
// srio_nread_responder
//   Target-side NREAD responder for the SRIO Gen2 HELLO request stream.
//   Answers supported NREADs with a RESPONSE-with-data packet whose payload
//   is read from a local 64-bit word memory. User logic fills that memory
//   through a simple write port.
//
//   Optional feature: define SRIO_RESP_ERR_EN to answer unsupported FTYPE 2/5
//   requests with a single ERROR response beat instead of dropping them silently.
//
//   Ports
//     log_clk, log_rst_n       clock, asynchronous active-low reset
//     treq_*                   HELLO request AXI4-Stream (sink)
//     tresp_*                  HELLO response AXI4-Stream (source)
//     mem_we/mem_waddr/wdata   local memory write port
//     nread_cnt, drop_cnt      saturating event counters
//     busy                     high whenever the FSM is not idle
module srio_nread_responder #(
  parameter int unsigned MEM_AW    = 6,
  parameter int unsigned MAX_BEATS = 32
) (
  input  logic              log_clk,
  input  logic              log_rst_n,
  input  logic              treq_tvalid,
  output logic              treq_tready,
  input  logic [63:0]       treq_tdata,
  input  logic [7:0]        treq_tkeep,
  input  logic              treq_tlast,
  input  logic [31:0]       treq_tuser,
  output logic              tresp_tvalid,
  input  logic              tresp_tready,
  output logic [63:0]       tresp_tdata,
  output logic [7:0]        tresp_tkeep,
  output logic              tresp_tlast,
  output logic [31:0]       tresp_tuser,
  input  logic              mem_we,
  input  logic [MEM_AW-1:0] mem_waddr,
  input  logic [63:0]       mem_wdata,
  output logic [15:0]       nread_cnt,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RESP_HDR  = 3'd1;
  localparam logic [2:0] RESP_DATA = 3'd2;
  localparam logic [2:0] DRAIN     = 3'd3;
`ifdef SRIO_RESP_ERR_EN
  localparam logic [2:0] ERR_HDR   = 3'd4;
`endif

  logic [63:0]       mem [DEPTH];

  logic [2:0]        state_r;
  logic              run_r;
  logic [7:0]        tid_r;
  logic [1:0]        prio_r;
  logic              crf_r;
  logic [31:0]       user_r;
  logic [MEM_AW-1:0] ptr_r;
  logic [5:0]        left_r;
  logic [63:0]       data_r;
  logic [15:0]       nread_r;
  logic [15:0]       drop_r;
`ifdef SRIO_RESP_ERR_EN
  logic              err_pend_r;
`endif

  // Header beat fields
  logic [7:0]        h_tid;
  logic [3:0]        h_ftype;
  logic [3:0]        h_ttype;
  logic [1:0]        h_prio;
  logic              h_crf;
  logic [7:0]        h_size;
  logic [33:0]       h_addr;
  logic [8:0]        h_len;
  logic [5:0]        h_beats;
  logic              h_ok;
  logic [1:0]        h_prio_nxt;
  logic [MEM_AW-1:0] ptr_nxt;
  logic              req_hs;
  logic              rsp_hs;
  logic              unused_bits;

  assign h_tid   = treq_tdata[63:56];
  assign h_ftype = treq_tdata[55:52];
  assign h_ttype = treq_tdata[51:48];
  assign h_prio  = treq_tdata[46:45];
  assign h_crf   = treq_tdata[44];
  assign h_size  = treq_tdata[43:36];
  assign h_addr  = treq_tdata[33:0];
  assign h_len   = {1'b0, h_size} + 9'd1;
  assign h_beats = h_len[8:3];

  assign h_ok = (h_ftype == 4'h2) && (h_ttype == 4'h4) &&
                (h_addr[2:0] == 3'b000) && (h_size[2:0] == 3'b111) &&
                ({26'd0, h_beats} <= MAX_BEATS) &&
                ((h_addr >> (MEM_AW + 3)) == 34'd0) &&
                treq_tlast;

  assign h_prio_nxt = (h_prio == 2'd3) ? 2'd3 : h_prio + 2'd1;
  assign ptr_nxt    = ptr_r + MEM_AW'(1);

  assign unused_bits = ^{treq_tdata[47], treq_tdata[35:34], treq_tkeep, h_len[2:0]};

  // run_r keeps treq_tready low during reset and its first released cycle
  assign treq_tready  = run_r && ((state_r == IDLE) || (state_r == DRAIN));
`ifdef SRIO_RESP_ERR_EN
  assign tresp_tvalid = (state_r == RESP_HDR) || (state_r == RESP_DATA) ||
                        (state_r == ERR_HDR);
  assign tresp_tlast  = ((state_r == RESP_DATA) && (left_r == 6'd0)) ||
                        (state_r == ERR_HDR);
`else
  assign tresp_tvalid = (state_r == RESP_HDR) || (state_r == RESP_DATA);
  assign tresp_tlast  = (state_r == RESP_DATA) && (left_r == 6'd0);
`endif
  assign tresp_tkeep  = tresp_tvalid ? '1 : '0;
  assign tresp_tuser  = user_r;
  assign nread_cnt    = nread_r;
  assign drop_cnt     = drop_r;
  assign busy         = (state_r != IDLE);

  assign req_hs = treq_tvalid && treq_tready;
  assign rsp_hs = tresp_tvalid && tresp_tready;

  always_comb begin
    tresp_tdata = '0;
    case (state_r)
      RESP_HDR:  tresp_tdata = {tid_r, 4'hD, 4'h8, 1'b0, prio_r, crf_r, 44'h0};
      RESP_DATA: tresp_tdata = data_r;
`ifdef SRIO_RESP_ERR_EN
      ERR_HDR:   tresp_tdata = {tid_r, 4'hD, 4'h0, 1'b0, prio_r, crf_r, 8'h0,
                                4'b0111, 32'h0};
`endif
      default:   tresp_tdata = '0;
    endcase
  end

  // No reset: contents survive reset, and writes land in any state.
  // Reads elsewhere see the pre-write value (read-first).
  always_ff @(posedge log_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      state_r    <= IDLE;
      run_r      <= 1'b0;
      tid_r      <= '0;
      prio_r     <= '0;
      crf_r      <= 1'b0;
      user_r     <= '0;
      ptr_r      <= '0;
      left_r     <= '0;
      data_r     <= '0;
      nread_r    <= '0;
      drop_r     <= '0;
`ifdef SRIO_RESP_ERR_EN
      err_pend_r <= 1'b0;
`endif
    end else begin
      run_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (req_hs) begin
            tid_r  <= h_tid;
            prio_r <= h_prio_nxt;
            crf_r  <= h_crf;
            user_r <= {treq_tuser[15:0], treq_tuser[31:16]};
            if (h_ok) begin
              ptr_r   <= h_addr[MEM_AW+2:3];
              left_r  <= h_beats - 6'd1;
              state_r <= RESP_HDR;
            end else begin
              if (drop_r != 16'hFFFF) drop_r <= drop_r + 16'd1;
`ifdef SRIO_RESP_ERR_EN
              err_pend_r <= (h_ftype == 4'h2) || (h_ftype == 4'h5);
              if (!treq_tlast)
                state_r <= DRAIN;
              else if ((h_ftype == 4'h2) || (h_ftype == 4'h5))
                state_r <= ERR_HDR;
              else
                state_r <= IDLE;
`else
              state_r <= treq_tlast ? IDLE : DRAIN;
`endif
            end
          end
        end
        DRAIN: begin
          if (req_hs && treq_tlast) begin
`ifdef SRIO_RESP_ERR_EN
            state_r <= err_pend_r ? ERR_HDR : IDLE;
`else
            state_r <= IDLE;
`endif
          end
        end
        RESP_HDR: begin
          // Refresh every cycle so the first data beat is ready the cycle
          // after the header handshake, with no bubble.
          data_r <= mem[ptr_r];
          if (rsp_hs) state_r <= RESP_DATA;
        end
        RESP_DATA: begin
          if (rsp_hs) begin
            if (left_r == 6'd0) begin
              if (nread_r != 16'hFFFF) nread_r <= nread_r + 16'd1;
              state_r <= IDLE;
            end else begin
              left_r <= left_r - 6'd1;
              ptr_r  <= ptr_nxt;
              data_r <= mem[ptr_nxt];
            end
          end
        end
`ifdef SRIO_RESP_ERR_EN
        ERR_HDR: begin
          if (rsp_hs) state_r <= IDLE;
        end
`endif
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srio_nread_responder.sv
// Testbench for srio_nread_responder: directed scenarios followed by random
// request traffic, checked against a transaction-level reference model.
module tb_srio_nread_responder;

  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned MAXB  = 32;

  logic          log_clk = 1'b0;
  logic          log_rst_n;
  logic          treq_tvalid;
  logic          treq_tready;
  logic [63:0]   treq_tdata;
  logic [7:0]    treq_tkeep;
  logic          treq_tlast;
  logic [31:0]   treq_tuser;
  logic          tresp_tvalid;
  logic          tresp_tready;
  logic [63:0]   tresp_tdata;
  logic [7:0]    tresp_tkeep;
  logic          tresp_tlast;
  logic [31:0]   tresp_tuser;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [63:0]   mem_wdata;
  logic [15:0]   nread_cnt;
  logic [15:0]   drop_cnt;
  logic          busy;

  srio_nread_responder #(.MEM_AW(AW), .MAX_BEATS(MAXB)) dut (
    .log_clk(log_clk), .log_rst_n(log_rst_n),
    .treq_tvalid(treq_tvalid), .treq_tready(treq_tready),
    .treq_tdata(treq_tdata), .treq_tkeep(treq_tkeep),
    .treq_tlast(treq_tlast), .treq_tuser(treq_tuser),
    .tresp_tvalid(tresp_tvalid), .tresp_tready(tresp_tready),
    .tresp_tdata(tresp_tdata), .tresp_tkeep(tresp_tkeep),
    .tresp_tlast(tresp_tlast), .tresp_tuser(tresp_tuser),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .nread_cnt(nread_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 log_clk = ~log_clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] model [DEPTH];
  int          exp_nread = 0;
  int          exp_drop  = 0;

  logic [63:0] got_d [$];
  logic        got_l [$];
  logic [31:0] got_u [$];
  int          got_c [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input int a, input logic [63:0] d);
    mem_we = 1'b1; mem_waddr = AW'(a); mem_wdata = d;
    @(negedge log_clk);
    mem_we = 1'b0;
    model[a] = d;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [31:0] u);
    int w;
    treq_tdata = d; treq_tlast = last; treq_tuser = u;
    treq_tkeep = 8'($urandom); treq_tvalid = 1'b1;
    w = 0;
    #1;
    while (!treq_tready && w < 50) begin
      @(negedge log_clk); #1; w++;
    end
    chk("req_accept", {63'd0, treq_tready}, 64'd1);
    @(negedge log_clk);
    treq_tvalid = 1'b0; treq_tlast = 1'b0;
  endtask

  // Collects one response packet; random ready when rmode != 0.
  task automatic recv_resp(input int rmode);
    logic        stall, done;
    logic [63:0] pd;
    logic        pl;
    int          cyc;
    got_d.delete(); got_l.delete(); got_u.delete(); got_c.delete();
    stall = 1'b0; done = 1'b0; cyc = 0; pd = '0; pl = 1'b0;
    while (!done && cyc < 400) begin
      tresp_tready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        chk("stall_valid", {63'd0, tresp_tvalid}, 64'd1);
        chk("stall_data", tresp_tdata, pd);
        chk("stall_last", {63'd0, tresp_tlast}, {63'd0, pl});
      end
      if (tresp_tvalid && tresp_tready) begin
        got_d.push_back(tresp_tdata); got_l.push_back(tresp_tlast);
        got_u.push_back(tresp_tuser); got_c.push_back(cyc);
        chk("tkeep", {56'd0, tresp_tkeep}, 64'hFF);
        done = tresp_tlast; stall = 1'b0;
      end else if (tresp_tvalid) begin
        stall = 1'b1; pd = tresp_tdata; pl = tresp_tlast;
      end else begin
        stall = 1'b0;
      end
      @(negedge log_clk); cyc++;
    end
    tresp_tready = 1'b0;
    chk("resp_complete", {63'd0, done}, 64'd1);
  endtask

  task automatic quiet_check(input string tag);
    logic seen;
    seen = 1'b0;
    tresp_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1; seen = seen | tresp_tvalid;
      @(negedge log_clk);
    end
    tresp_tready = 1'b0;
    chk(tag, {63'd0, seen}, 64'd0);
  endtask

  // One request transaction; expectation derived from the request rules.
  task automatic do_txn(input logic [7:0] tid, input logic [3:0] ftype, input logic [3:0] ttype,
                        input logic [1:0] prio, input logic crf, input logic [7:0] size,
                        input logic [33:0] addr, input int nextra, input logic [31:0] user,
                        input int rmode);
    logic [63:0] exp_q [$];
    logic [63:0] pi;
    int          nb, base;
    logic        ok;
    pi = 64'(prio) + 64'd1;
    if (pi > 64'd3) pi = 64'd3;
    nb = (int'(size) + 1) / 8;
    ok = (ftype == 4'h2) && (ttype == 4'h4) && (addr % 8 == 0) &&
         ((int'(size) + 1) % 8 == 0) && (nb <= int'(MAXB)) &&
         (addr < 34'(DEPTH * 8)) && (nextra == 0);
    if (ok) begin
      base = int'(addr / 8);
      exp_q.push_back((64'(tid) << 56) | (64'hD8 << 48) | (pi << 45) | (64'(crf) << 44));
      for (int i = 0; i < nb; i++) exp_q.push_back(model[(base + i) % DEPTH]);
      if (exp_nread < 65535) exp_nread++;
    end else begin
      if (exp_drop < 65535) exp_drop++;
`ifdef SRIO_RESP_ERR_EN
      if (ftype == 4'h2 || ftype == 4'h5)
        exp_q.push_back((64'(tid) << 56) | (64'hD0 << 48) | (pi << 45) |
                        (64'(crf) << 44) | (64'h7 << 32));
`endif
    end
    send_beat({tid, ftype, ttype, 1'b0, prio, crf, size, 2'b00, addr}, nextra == 0, user);
    for (int i = 0; i < nextra; i++)
      send_beat({$urandom, $urandom}, i == nextra - 1, user);
    if (exp_q.size() > 0) begin
      recv_resp(rmode);
      chk("resp_len", 64'(got_d.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
        chk("resp_data", got_d[i], exp_q[i]);
        chk("resp_last", {63'd0, got_l[i]}, {63'd0, i == exp_q.size() - 1});
        chk("resp_tuser", {32'd0, got_u[i]}, {32'd0, user[15:0], user[31:16]});
        if (rmode == 0) chk("no_bubble", 64'(got_c[i]), 64'(got_c[0] + i));
      end
    end else begin
      quiet_check("no_resp");
    end
    chk("nread_cnt", {48'd0, nread_cnt}, 64'(exp_nread));
    chk("drop_cnt", {48'd0, drop_cnt}, 64'(exp_drop));
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int          hs, cyc, r, ft, nw, wd, nb;
    logic [3:0]  ftype, ttype;
    logic [7:0]  size;
    logic [33:0] addr;
    logic [63:0] w127, w0;

    log_rst_n = 1'b0; treq_tvalid = 1'b0; treq_tdata = '0; treq_tkeep = '0;
    treq_tlast = 1'b0; treq_tuser = '0; tresp_tready = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    @(negedge log_clk);

    // Memory is filled while reset is still asserted
    for (int i = 0; i < int'(DEPTH); i++) mem_wr(i, {$urandom, $urandom});
    #1;
    chk("rst_tvalid", {63'd0, tresp_tvalid}, 64'd0);
    chk("rst_tready", {63'd0, treq_tready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_nread", {48'd0, nread_cnt}, 64'd0);
    chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("rst_tdata", tresp_tdata, 64'd0);
    chk("rst_tkeep", {56'd0, tresp_tkeep}, 64'd0);
    @(negedge log_clk);
    log_rst_n = 1'b1;
    @(negedge log_clk);

    // 1: basic 4-beat NREAD
    mem_wr(0, {16{4'h1}}); mem_wr(1, {16{4'h2}});
    mem_wr(2, {16{4'h3}}); mem_wr(3, {16{4'h4}});
    do_txn(8'h5A, 4'h2, 4'h4, 2'd1, 1'b0, 8'h1F, 34'h0, 0, 32'h0001_0002, 0);
    chk("t1_hdr", got_d[0], 64'h5AD8_4000_0000_0000);
    chk("t1_tuser", {32'd0, got_u[0]}, 64'h0000_0000_0002_0001);
    chk("t1_beat4", got_d[4], {16{4'h4}});

    // 2: same request with random backpressure
    do_txn(8'h5A, 4'h2, 4'h4, 2'd1, 1'b0, 8'h1F, 34'h0, 0, 32'h0001_0002, 1);

    // 3: NWRITE header plus three payload beats
    do_txn(8'h21, 4'h5, 4'h4, 2'd0, 1'b1, 8'h17, 34'h40, 3, 32'h0003_0004, 0);

    // 4: wrap-around from the last word to word 0
    w127 = {$urandom, $urandom}; w0 = {$urandom, $urandom};
    mem_wr(127, w127); mem_wr(0, w0);
    do_txn(8'h33, 4'h2, 4'h4, 2'd3, 1'b1, 8'h0F, 34'h3F8, 0, 32'hABCD_1234, 0);
    chk("t4_word127", got_d[1], w127);
    chk("t4_word0", got_d[2], w0);

    // 5: unaligned address rejected, next valid request answered
    do_txn(8'h44, 4'h2, 4'h4, 2'd2, 1'b0, 8'h07, 34'h4, 0, 32'h0005_0006, 0);
    do_txn(8'h45, 4'h2, 4'h4, 2'd2, 1'b0, 8'h07, 34'h8, 0, 32'h0005_0006, 1);

    // Random traffic
    for (int t = 0; t < 30; t++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        wd = $urandom_range(0, DEPTH - 1);
        mem_wr(wd, {$urandom, $urandom});
      end
      r = $urandom_range(0, 9);
      ftype = (r < 7) ? 4'h2 : (r < 9) ? 4'h5 : 4'($urandom);
      ttype = ($urandom_range(0, 9) < 9) ? 4'h4 : 4'($urandom);
      nb = $urandom_range(1, 32);
      size = ($urandom_range(0, 9) < 8) ? 8'(nb * 8 - 1) : 8'($urandom);
      addr = 34'($urandom_range(0, DEPTH - 1)) << 3;
      r = $urandom_range(0, 9);
      if (r == 0) addr = addr | 34'($urandom_range(1, 7));
      if (r == 1) addr = addr | (34'($urandom_range(1, 3)) << (AW + 3));
      ft = (ftype == 4'h5) ? $urandom_range(0, 3) :
           (($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
      do_txn(8'($urandom), ftype, ttype, 2'($urandom), 1'($urandom), size, addr, ft,
             $urandom, $urandom_range(0, 1));
    end

    // 6: reset during beat 2 of a 32-beat response
    send_beat({8'h77, 4'h2, 4'h4, 1'b0, 2'd0, 1'b0, 8'hFF, 2'b00, 34'h0}, 1'b1, 32'h1111_2222);
    tresp_tready = 1'b1; hs = 0; cyc = 0;
    while (hs < 2 && cyc < 100) begin
      #1; if (tresp_tvalid) hs++;
      @(negedge log_clk); cyc++;
    end
    chk("t6_reach_beat2", 64'(hs), 64'd2);
    #1;
    chk("t6_beat2", tresp_tdata, model[1]);
    log_rst_n = 1'b0;
    #1;
    exp_nread = 0; exp_drop = 0;
    chk("t6_tvalid", {63'd0, tresp_tvalid}, 64'd0);
    chk("t6_nread", {48'd0, nread_cnt}, 64'd0);
    chk("t6_drop", {48'd0, drop_cnt}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    tresp_tready = 1'b0;
    @(negedge log_clk);
    log_rst_n = 1'b1;
    @(negedge log_clk);
    do_txn(8'h78, 4'h2, 4'h4, 2'd2, 1'b1, 8'h17, 34'h100, 0, 32'h0009_000A, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
